alu_result_sender: RTL and testbench
====================================

# alu_result_sender

Drains registered ALU results toward the UART transmitter. It captures each `ALU_OUT` word when `OUT_VALID` pulses, splits the word into bytes (least-significant byte first) and hands them one at a time to the UART TX over its `TX_D_VLD`/`TX_BUSY` handshake. It sits between the ALU output register and the UART TX in the system datapath, and reports back-pressure and dropped results to the system controller.

## Interface
Parameters:
- `OUT_WIDTH`, 16: ALU result width in bits; must be a multiple of 8 and at least 8.
- `NUM_BYTES`, `OUT_WIDTH/8`: derived; bytes sent per result.
- `HDR_BYTE`, 8'hA5: header value, used only when the header feature is compiled in.

Ports:
- `CLK` input 1: single clock; all logic on the rising edge.
- `RST` input 1: reset; asynchronous, active-low.
- `ALU_OUT` input `OUT_WIDTH`: ALU result word.
- `OUT_VALID` input 1: one-cycle pulse; `ALU_OUT` is valid in the same cycle.
- `TX_BUSY` input 1: high while the UART TX is serialising a byte.
- `TX_P_DATA` output 8: byte offered to the UART TX.
- `TX_D_VLD` output 1: `TX_P_DATA` is valid.
- `RSP_BUSY` output 1: a result is held or is being sent; the controller must not start a new ALU op while this is high.
- `OVERRUN` output 1: sticky flag; a result was dropped.

## Operation
- State machine: `IDLE` → (`HDR`, if compiled in) → `DATA` → `IDLE`.
- **Capture.** In `IDLE`, `OUT_VALID=1` loads `ALU_OUT` into the shift register and sets the byte counter to 0.
  - The next state is `HDR` if the header is compiled in, otherwise `DATA`.
- **Byte acceptance.** A byte is accepted on a rising edge where `TX_D_VLD=1` and `TX_BUSY=0`. Nothing else counts as acceptance.
- **`TX_D_VLD`** is high in `HDR` and `DATA`, low in `IDLE`.
- **`TX_P_DATA`** carries `HDR_BYTE` in `HDR` and the shift register's low byte in `DATA`.
  - `TX_P_DATA` is held stable until the byte is accepted.
  - In `IDLE`, `TX_P_DATA` is 0.
- **In `HDR`,** acceptance moves the block to `DATA`.
- **In `DATA`,** acceptance shifts the register right by 8 and increments the counter.
  - When the accepted byte is number `NUM_BYTES-1`, the block returns to `IDLE`.
- **`RSP_BUSY`** equals (state != `IDLE`).
- **`OUT_VALID` while busy.** A pulse outside `IDLE` drops that result and sets `OVERRUN`.
  - One exception: a pulse on the same edge that accepts the last byte is captured as a back-to-back capture, not an overrun.
  - In that case the block goes straight to `HDR`/`DATA` with `TX_D_VLD` still high.
- **`OVERRUN`** is cleared only by reset.

## Timing
- All outputs reset to 0: `TX_P_DATA`, `TX_D_VLD`, `RSP_BUSY`, `OVERRUN`. The state resets to `IDLE` and the counter and shift register to 0.
- Latency: with `OUT_VALID` sampled at edge k, `TX_D_VLD` and `RSP_BUSY` are high from k+1. All outputs are registered.
- The UART TX asserts `TX_BUSY` the cycle after acceptance. Because of that, `TX_D_VLD` may stay high across bytes while the next byte waits for `TX_BUSY=0`.
- Best case: with `TX_BUSY` stuck low, one byte is accepted per cycle. `NUM_BYTES` (+1 with the header) cycles pass from capture to `IDLE`.
- Reset asserted mid-transfer: outputs go to 0 immediately (asynchronously). The pending result is discarded and nothing resumes after release.

## Configuration
- Macro: `ALU_RSP_HDR_EN`.
- **Defined:** `HDR` is compiled in. Every result is prefixed by one `HDR_BYTE`, so a frame is `NUM_BYTES+1` bytes.
- **Undefined:** `HDR` and `HDR_BYTE` are unused. A frame is exactly `NUM_BYTES` bytes and capture goes directly to `DATA`.

## Test plan
All scenarios use `OUT_WIDTH=16`.
1. **Reset values.** Assert `RST=0` with random inputs → all outputs 0. Release, keep `OUT_VALID=0` → outputs stay 0.
2. **Basic send, header off.** `TX_BUSY=0`, `OUT_VALID` pulse with `ALU_OUT=16'h1234` → bytes 8'h34 then 8'h12 accepted on consecutive edges. `RSP_BUSY` is high for exactly 2 cycles.
3. **Back-pressure.** After each acceptance, `TX_BUSY` is held high for 10 cycles. `ALU_OUT=16'h00FF` → `TX_P_DATA` holds 8'h00 stable through the busy window and is accepted only when `TX_BUSY` falls.
4. **Overrun.** With `TX_BUSY=1`, send a second `OUT_VALID` (`ALU_OUT=16'hBEEF`) while busy → it is dropped, `OVERRUN=1` sticks, and only the first result is sent.
5. **Back-to-back capture.** `OUT_VALID` (`ALU_OUT=16'h0003`) on the edge that accepts the last byte of 16'hAAAA → `OVERRUN` stays 0. The sequence is AA, AA, 03, 00 and `RSP_BUSY` never drops.
6. **Header and reset mid-frame.** With `ALU_RSP_HDR_EN` defined, `ALU_OUT=16'h5678` sends A5, 78, 56. Reset asserted after A5 → outputs are 0 at once and no further bytes follow release.

Source files
------------

// File: rtl/alu_result_sender.sv
// Sends each captured ALU result to the UART TX as bytes, LSB first, over TX_D_VLD/TX_BUSY.
// Define ALU_RSP_HDR_EN to prefix every frame with one HDR_BYTE.
module alu_result_sender #(
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned NUM_BYTES = OUT_WIDTH / 8,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [OUT_WIDTH-1:0] ALU_OUT,
    input  logic                 OUT_VALID,
    input  logic                 TX_BUSY,
    output logic [7:0]           TX_P_DATA,
    output logic                 TX_D_VLD,
    output logic                 RSP_BUSY,
    output logic                 OVERRUN
);

    localparam int unsigned CntW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

`ifdef ALU_RSP_HDR_EN
    localparam state_e StFirst = StHdr;
`else
    localparam state_e StFirst = StData;
`endif

    state_e               state_q, state_d;
    logic [OUT_WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_vld_q, tx_vld_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    logic accept;
    logic last_byte;

    assign accept    = tx_vld_q && !TX_BUSY;
    assign last_byte = (cnt_q == CntW'(NUM_BYTES - 1));

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (OUT_VALID) begin
                    shreg_d = ALU_OUT;
                    cnt_d   = '0;
                    state_d = StFirst;
                end
            end
            StHdr: begin
                if (accept) begin
                    state_d = StData;
                end
                if (OUT_VALID) begin
                    overrun_d = 1'b1;
                end
            end
            StData: begin
                if (accept) begin
                    shreg_d = shreg_q >> 8;
                    cnt_d   = cnt_q + CntW'(1);
                    if (last_byte) begin
                        state_d = StIdle;
                    end
                end
                // A pulse on the edge that takes the last byte starts the next frame at once.
                if (OUT_VALID) begin
                    if (accept && last_byte) begin
                        shreg_d = ALU_OUT;
                        cnt_d   = '0;
                        state_d = StFirst;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with it.
        tx_vld_d = (state_d != StIdle);
        busy_d   = (state_d != StIdle);
        unique case (state_d)
            StHdr:   tx_data_d = HDR_BYTE;
            StData:  tx_data_d = shreg_d[7:0];
            default: tx_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign RSP_BUSY  = busy_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_alu_result_sender.sv
// Directed self-checking bench for alu_result_sender (OUT_WIDTH=16).
// Header expectations follow ALU_RSP_HDR_EN when the bench is built with it.
module tb_alu_result_sender;

    logic        CLK;
    logic        RST;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        TX_BUSY;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        RSP_BUSY;
    logic        OVERRUN;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  rx_q[$];

    alu_result_sender #(
        .OUT_WIDTH(16)
    ) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .ALU_OUT  (ALU_OUT),
        .OUT_VALID(OUT_VALID),
        .TX_BUSY  (TX_BUSY),
        .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD (TX_D_VLD),
        .RSP_BUSY (RSP_BUSY),
        .OVERRUN  (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs only change 1ns after a rising edge, so the falling edge sees what the next edge sees.
    always @(negedge CLK) begin
        if (RST && TX_D_VLD && !TX_BUSY) rx_q.push_back(TX_P_DATA);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".vld"}, {31'd0, TX_D_VLD}, 32'd0);
        check_eq({tag, ".data"}, {24'd0, TX_P_DATA}, 32'd0);
        check_eq({tag, ".busy"}, {31'd0, RSP_BUSY}, 32'd0);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp[$]);
        check_eq({tag, ".count"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            check_eq($sformatf("%s.byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp[i]});
        end
        rx_q.delete();
    endtask

    task automatic do_reset();
        RST       = 1'b0;
        OUT_VALID = 1'b0;
        TX_BUSY   = 1'b0;
        ALU_OUT   = '0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        rx_q.delete();
    endtask

    task automatic capture(input logic [15:0] word);
        ALU_OUT   = word;
        OUT_VALID = 1'b1;
        tick();
        OUT_VALID = 1'b0;
    endtask

    logic [7:0] exp_q[$];

    initial begin
        // Reset values with random inputs.
        RST       = 1'b0;
        ALU_OUT   = 16'($urandom);
        OUT_VALID = 1'($urandom);
        TX_BUSY   = 1'($urandom);
        #3;
        check_idle("rst");
        check_eq("rst.ovr", {31'd0, OVERRUN}, 32'd0);
        tick();
        tick();
        check_idle("rst_hold");
        OUT_VALID = 1'b0;
        TX_BUSY   = 1'b0;
        RST       = 1'b1;
        repeat (3) tick();
        check_idle("rel");
        check_eq("rel.ovr", {31'd0, OVERRUN}, 32'd0);
        rx_q.delete();

        // Basic send (header bytes come first when compiled in).
        capture(16'h1234);
`ifdef ALU_RSP_HDR_EN
        check_eq("basic.hdr", {24'd0, TX_P_DATA}, 32'hA5);
        tick();
`endif
        check_eq("basic.vld0", {31'd0, TX_D_VLD}, 32'd1);
        check_eq("basic.busy0", {31'd0, RSP_BUSY}, 32'd1);
        check_eq("basic.b0", {24'd0, TX_P_DATA}, 32'h34);
        tick();
        check_eq("basic.busy1", {31'd0, RSP_BUSY}, 32'd1);
        check_eq("basic.b1", {24'd0, TX_P_DATA}, 32'h12);
        tick();
        check_idle("basic.end");
        exp_q = '{8'h34, 8'h12};
`ifdef ALU_RSP_HDR_EN
        exp_q.push_front(8'hA5);
`endif
        check_rx("basic", exp_q);

        // Back-pressure: UART busy for 10 cycles after each acceptance.
        capture(16'h00FF);
`ifdef ALU_RSP_HDR_EN
        tick();
        TX_BUSY = 1'b1;
        repeat (10) tick();
        TX_BUSY = 1'b0;
`endif
        check_eq("bp.b0", {24'd0, TX_P_DATA}, 32'hFF);
        tick();
        TX_BUSY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("bp.hold%0d", i), {23'd0, TX_D_VLD, TX_P_DATA}, 32'h100);
        end
        TX_BUSY = 1'b0;
        tick();
        TX_BUSY = 1'b1;
        repeat (10) tick();
        TX_BUSY = 1'b0;
        check_idle("bp.end");
        exp_q = '{8'hFF, 8'h00};
`ifdef ALU_RSP_HDR_EN
        exp_q.push_front(8'hA5);
`endif
        check_rx("bp", exp_q);

        // Overrun: second result while busy is dropped.
        TX_BUSY = 1'b1;
        capture(16'hC3A1);
        tick();
        capture(16'hBEEF);
        check_eq("ovr.set", {31'd0, OVERRUN}, 32'd1);
        TX_BUSY = 1'b0;
        repeat (6) tick();
        check_idle("ovr.end");
        check_eq("ovr.sticky", {31'd0, OVERRUN}, 32'd1);
        exp_q = '{8'hA1, 8'hC3};
`ifdef ALU_RSP_HDR_EN
        exp_q.push_front(8'hA5);
`endif
        check_rx("ovr", exp_q);

        // Back-to-back capture on the last-byte edge.
        do_reset();
        check_eq("b2b.ovr_clr", {31'd0, OVERRUN}, 32'd0);
        capture(16'hAAAA);
`ifdef ALU_RSP_HDR_EN
        tick();
`endif
        tick();
        check_eq("b2b.busy_a", {31'd0, RSP_BUSY}, 32'd1);
        capture(16'h0003);
        check_eq("b2b.busy_b", {31'd0, RSP_BUSY}, 32'd1);
        check_eq("b2b.vld", {31'd0, TX_D_VLD}, 32'd1);
`ifdef ALU_RSP_HDR_EN
        tick();
        check_eq("b2b.busy_h", {31'd0, RSP_BUSY}, 32'd1);
`endif
        check_eq("b2b.b2", {24'd0, TX_P_DATA}, 32'h03);
        tick();
        check_eq("b2b.busy_c", {31'd0, RSP_BUSY}, 32'd1);
        check_eq("b2b.b3", {24'd0, TX_P_DATA}, 32'h00);
        tick();
        check_idle("b2b.end");
        check_eq("b2b.ovr", {31'd0, OVERRUN}, 32'd0);
        exp_q = '{8'hAA, 8'hAA, 8'h03, 8'h00};
`ifdef ALU_RSP_HDR_EN
        exp_q = '{8'hA5, 8'hAA, 8'hAA, 8'hA5, 8'h03, 8'h00};
`endif
        check_rx("b2b", exp_q);

        // Reset mid-frame after the first byte goes out.
        capture(16'h5678);
`ifdef ALU_RSP_HDR_EN
        check_eq("mid.hdr", {24'd0, TX_P_DATA}, 32'hA5);
`else
        check_eq("mid.b0", {24'd0, TX_P_DATA}, 32'h78);
`endif
        tick();
        RST = 1'b0;
        #1;
        check_idle("mid.async");
        tick();
        RST = 1'b1;
        repeat (5) tick();
        check_idle("mid.after");
`ifdef ALU_RSP_HDR_EN
        exp_q = '{8'hA5};
`else
        exp_q = '{8'h78};
`endif
        check_rx("mid", exp_q);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
